// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register.
// Holds the field widths, the opcodes the hazard logic needs, the packed
// control-field payload, its bubble encoding and the rs1-usage decode.
package id_ex_stage_pkg;

    localparam int unsigned OPC_W  = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned FS_W   = 4;
    localparam int unsigned STRB_W = 4;

    localparam logic [OPC_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_LOAD  = 7'b0000011;

    // Decoded control fields carried from ID into EX.
    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic [F3_W-1:0]   funct3;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic              rw;
        logic              mw;
        logic              md;
        logic              mb;
        logic              mp;
        logic [FS_W-1:0]   fs;
        logic [STRB_W-1:0] strb;
    } ctrl_t;

    // A bubble is the all-zero encoding: not valid, no reg or mem write.
    localparam ctrl_t CTRL_NOP = '0;

    // LUI, AUIPC and JAL carry no rs1 operand.
    function automatic logic uses_rs1(input logic [OPC_W-1:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side and EX-side bundle of the ID/EX pipeline register.
// master: decode side drives id_*, observes ex_*.
// slave : pipeline register reads id_*, drives ex_*.
interface id_ex_stage_if #(parameter int unsigned XLEN = 32);
    import id_ex_stage_pkg::*;

    logic              id_valid,    ex_valid;
    logic [OPC_W-1:0]  id_opcode,   ex_opcode;
    logic [F3_W-1:0]   id_funct3,   ex_funct3;
    logic [REG_W-1:0]  id_rd,       ex_rd;
    logic [REG_W-1:0]  id_rs1,      ex_rs1;
    logic [REG_W-1:0]  id_rs2,      ex_rs2;
    logic              id_rw,       ex_rw;
    logic              id_mw,       ex_mw;
    logic              id_md,       ex_md;
    logic              id_mb,       ex_mb;
    logic              id_mp,       ex_mp;
    logic [FS_W-1:0]   id_fs,       ex_fs;
    logic [STRB_W-1:0] id_strb,     ex_strb;
    logic [XLEN-1:0]   id_imm,      ex_imm;
    logic [XLEN-1:0]   id_pc,       ex_pc;
    logic [XLEN-1:0]   id_rs1_data, ex_rs1_data;
    logic [XLEN-1:0]   id_rs2_data, ex_rs2_data;

    modport master (
        output id_valid, id_opcode, id_funct3, id_rd, id_rs1, id_rs2,
               id_rw, id_mw, id_md, id_mb, id_mp, id_fs, id_strb,
               id_imm, id_pc, id_rs1_data, id_rs2_data,
        input  ex_valid, ex_opcode, ex_funct3, ex_rd, ex_rs1, ex_rs2,
               ex_rw, ex_mw, ex_md, ex_mb, ex_mp, ex_fs, ex_strb,
               ex_imm, ex_pc, ex_rs1_data, ex_rs2_data
    );

    modport slave (
        input  id_valid, id_opcode, id_funct3, id_rd, id_rs1, id_rs2,
               id_rw, id_mw, id_md, id_mb, id_mp, id_fs, id_strb,
               id_imm, id_pc, id_rs1_data, id_rs2_data,
        output ex_valid, ex_opcode, ex_funct3, ex_rd, ex_rs1, ex_rs2,
               ex_rw, ex_mw, ex_md, ex_mb, ex_mp, ex_fs, ex_strb,
               ex_imm, ex_pc, ex_rs1_data, ex_rs2_data
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection.
// Inputs : ID source fields, EX destination/load fields, flush, reset.
// Outputs: hazard_o (bubble request), stall_o (freeze PC and IF/ID).
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             id_valid_i,
    input  logic [OPC_W-1:0] id_opcode_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_mb_i,
    input  logic             id_mw_i,
    input  logic             ex_valid_i,
    input  logic             ex_md_i,
    input  logic             ex_rw_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             flush_i,
    input  logic             rst_n_i,
    output logic             hazard_o,
    output logic             stall_o
);

    logic rs1_used;
    logic rs2_used;
    logic ex_is_load;

    // Stores read rs2 as data even though the ALU takes the immediate.
    assign rs1_used   = id_valid_i && uses_rs1(id_opcode_i);
    assign rs2_used   = id_valid_i && (!id_mb_i || id_mw_i);
    assign ex_is_load = ex_valid_i && ex_md_i && ex_rw_i && (ex_rd_i != '0);

    assign hazard_o = ex_is_load &&
                      ((rs1_used && (id_rs1_i == ex_rd_i)) ||
                       (rs2_used && (id_rs2_i == ex_rd_i)));

    // A taken branch discards the dependent instruction, so no freeze.
    assign stall_o = hazard_o && !flush_i && rst_n_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble counter.
// Ports: clk, reset (async active-low), hold (freeze), flush (branch taken),
//        bus (slave: id_* in, ex_* registered out), stall (combinational),
//        bubble_cnt (saturating count of inserted bubbles).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    id_ex_stage_if.slave      bus,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    ctrl_t            id_ctrl;
    ctrl_t            ctrl_q,     ctrl_d;
    logic [XLEN-1:0]  imm_q,      imm_d;
    logic [XLEN-1:0]  pc_q,       pc_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             hazard;

    // Pack the incoming control fields.
    always_comb begin
        id_ctrl        = CTRL_NOP;
        id_ctrl.valid  = bus.id_valid;
        id_ctrl.opcode = bus.id_opcode;
        id_ctrl.funct3 = bus.id_funct3;
        id_ctrl.rd     = bus.id_rd;
        id_ctrl.rs1    = bus.id_rs1;
        id_ctrl.rs2    = bus.id_rs2;
        id_ctrl.rw     = bus.id_rw;
        id_ctrl.mw     = bus.id_mw;
        id_ctrl.md     = bus.id_md;
        id_ctrl.mb     = bus.id_mb;
        id_ctrl.mp     = bus.id_mp;
        id_ctrl.fs     = bus.id_fs;
        id_ctrl.strb   = bus.id_strb;
    end

    id_ex_stage_hazard_detect u_hazard (
        .id_valid_i  (bus.id_valid),
        .id_opcode_i (bus.id_opcode),
        .id_rs1_i    (bus.id_rs1),
        .id_rs2_i    (bus.id_rs2),
        .id_mb_i     (bus.id_mb),
        .id_mw_i     (bus.id_mw),
        .ex_valid_i  (ctrl_q.valid),
        .ex_md_i     (ctrl_q.md),
        .ex_rw_i     (ctrl_q.rw),
        .ex_rd_i     (ctrl_q.rd),
        .flush_i     (flush),
        .rst_n_i     (reset),
        .hazard_o    (hazard),
        .stall_o     (stall)
    );

    // Next-state: hold > flush > hazard bubble > normal capture.
    always_comb begin
        ctrl_d     = ctrl_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        cnt_d      = cnt_q;
        if (hold) begin
            cnt_d = cnt_q;
        end else if (flush || hazard) begin
            ctrl_d     = CTRL_NOP;
            imm_d      = '0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            ctrl_d     = id_ctrl;
            imm_d      = bus.id_imm;
            pc_d       = bus.id_pc;
            rs1_data_d = bus.id_rs1_data;
            rs2_data_d = bus.id_rs2_data;
        end
    end

    // Register bank and bubble counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= CTRL_NOP;
            imm_q      <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.ex_valid    = ctrl_q.valid;
    assign bus.ex_opcode   = ctrl_q.opcode;
    assign bus.ex_funct3   = ctrl_q.funct3;
    assign bus.ex_rd       = ctrl_q.rd;
    assign bus.ex_rs1      = ctrl_q.rs1;
    assign bus.ex_rs2      = ctrl_q.rs2;
    assign bus.ex_rw       = ctrl_q.rw;
    assign bus.ex_mw       = ctrl_q.mw;
    assign bus.ex_md       = ctrl_q.md;
    assign bus.ex_mb       = ctrl_q.mb;
    assign bus.ex_mp       = ctrl_q.mp;
    assign bus.ex_fs       = ctrl_q.fs;
    assign bus.ex_strb     = ctrl_q.strb;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs1_data = rs1_data_q;
    assign bus.ex_rs2_data = rs2_data_q;
    assign bubble_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage (bubble counter built 4 bits wide).
module tb_id_ex_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic       flush;
    logic       stall;
    logic [3:0] bubble_cnt;
    int         checks = 0;
    int         errors = 0;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .flush      (flush),
        .bus        (bus),
        .stall      (stall),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_idle();
        bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_funct3 = '0;
        bus.id_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_rw = 1'b0; bus.id_mw = 1'b0; bus.id_md = 1'b0;
        bus.id_mb = 1'b0; bus.id_mp = 1'b0; bus.id_fs = '0; bus.id_strb = '0;
        bus.id_imm = '0; bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0;
    endtask

    task automatic id_load(input int rd, input int rs1);
        id_idle();
        bus.id_valid = 1'b1; bus.id_opcode = 7'b0000011; bus.id_funct3 = 3'd2;
        bus.id_rd = 5'(rd); bus.id_rs1 = 5'(rs1);
        bus.id_rw = 1'b1; bus.id_md = 1'b1; bus.id_mb = 1'b1; bus.id_imm = 32'h10;
    endtask

    task automatic id_add(input int rd, input int rs1, input int rs2);
        id_idle();
        bus.id_valid = 1'b1; bus.id_opcode = 7'b0110011;
        bus.id_rd = 5'(rd); bus.id_rs1 = 5'(rs1); bus.id_rs2 = 5'(rs2);
        bus.id_rw = 1'b1; bus.id_fs = 4'h2;
        bus.id_rs1_data = 32'hAAAA0001; bus.id_rs2_data = 32'h5555000F;
    endtask

    task automatic do_reset();
        reset = 1'b0; hold = 1'b0; flush = 1'b0; id_idle();
        step(); step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; hold = 1'b0; flush = 1'b0; id_idle();
        step(); step();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.ex_valid); end
        checks++; if ({bus.ex_rw, bus.ex_mw} !== 2'b00) begin errors++; $display("FAIL reset_rw_mw: got %b want 00", {bus.ex_rw, bus.ex_mw}); end
        checks++; if (bus.ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.ex_pc); end
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        reset = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        id_load(5, 1); step();
        id_add(7, 5, 6); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall); end
        step();
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_rw !== 1'b0) begin errors++; $display("FAIL lu_bubble: got valid=%b rw=%b want 0 0", bus.ex_valid, bus.ex_rw); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_len: got %b want 0", stall); end
        checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", bubble_cnt); end
        step();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== 7'b0110011 || bus.ex_rd !== 5'd7 || bus.ex_rs1 !== 5'd5)
            begin errors++; $display("FAIL lu_add_pass: got v=%b op=%b rd=%0d rs1=%0d want 1 0110011 7 5", bus.ex_valid, bus.ex_opcode, bus.ex_rd, bus.ex_rs1); end
        checks++; if (bus.ex_fs !== 4'h2 || bus.ex_rs1_data !== 32'hAAAA0001) begin errors++; $display("FAIL lu_add_data: got fs=%h d=%h want 2 aaaa0001", bus.ex_fs, bus.ex_rs1_data); end
        checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt_after: got %0d want 1", bubble_cnt); end
        // Store reads rs2 as data despite mb=1.
        id_load(5, 1); step();
        id_idle(); bus.id_valid = 1'b1; bus.id_opcode = 7'b0100011; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd5;
        bus.id_mw = 1'b1; bus.id_mb = 1'b1; bus.id_strb = 4'hF; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_store_rs2: got %b want 1", stall); end
        bus.id_mw = 1'b0; bus.id_opcode = 7'b0010011; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_imm_rs2_unused: got %b want 0", stall); end
        id_idle(); step();
    endtask

    task automatic test_source_not_used();
        do_reset();
        id_load(5, 1); step();
        id_idle(); bus.id_valid = 1'b1; bus.id_opcode = 7'b0110111; bus.id_rd = 5'd3; bus.id_rs1 = 5'd5;
        bus.id_rw = 1'b1; bus.id_mb = 1'b1; bus.id_imm = 32'h12345000; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lui_stall: got %b want 0", stall); end
        step();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== 7'b0110111 || bus.ex_imm !== 32'h12345000)
            begin errors++; $display("FAIL lui_pass: got v=%b op=%b imm=%h want 1 0110111 12345000", bus.ex_valid, bus.ex_opcode, bus.ex_imm); end
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL lui_cnt: got %0d want 0", bubble_cnt); end
        id_load(0, 2); step();
        id_add(4, 0, 0); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd0_stall: got %b want 0", stall); end
        step();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd4) begin errors++; $display("FAIL rd0_pass: got v=%b rd=%0d want 1 4", bus.ex_valid, bus.ex_rd); end
        id_idle();
    endtask

    task automatic test_flush();
        do_reset();
        id_load(5, 1); step();
        id_add(7, 5, 6); flush = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
        step(); flush = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_md !== 1'b0) begin errors++; $display("FAIL flush_bubble: got v=%b md=%b want 0 0", bus.ex_valid, bus.ex_md); end
        checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL flush_cnt: got %0d want 1", bubble_cnt); end
        step();
        checks++; if (bus.ex_valid !== 1'b1 || bubble_cnt !== 4'd1) begin errors++; $display("FAIL flush_resume: got v=%b cnt=%0d want 1 1", bus.ex_valid, bubble_cnt); end
        id_idle();
    endtask

    task automatic test_hold();
        do_reset();
        id_add(9, 1, 2); bus.id_pc = 32'h100; step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_add(10 + i, 3, 4); bus.id_pc = 32'(32'h200 + 4 * i);
            flush = (i == 1);
            step();
            checks++; if (bus.ex_rd !== 5'd9 || bus.ex_pc !== 32'h100 || bubble_cnt !== 4'd0)
                begin errors++; $display("FAIL hold_frozen[%0d]: got rd=%0d pc=%h cnt=%0d want 9 100 0", i, bus.ex_rd, bus.ex_pc, bubble_cnt); end
        end
        hold = 1'b0; flush = 1'b0;
        id_add(12, 3, 4); bus.id_pc = 32'h300; step();
        checks++; if (bus.ex_rd !== 5'd12 || bus.ex_pc !== 32'h300) begin errors++; $display("FAIL hold_release: got rd=%0d pc=%h want 12 300", bus.ex_rd, bus.ex_pc); end
        // Stall stays visible while held, and the load is kept in EX.
        id_load(5, 1); step();
        hold = 1'b1; id_add(7, 5, 6); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall: got %b want 1", stall); end
        step();
        checks++; if (bus.ex_md !== 1'b1 || bus.ex_rd !== 5'd5 || bubble_cnt !== 4'd0) begin errors++; $display("FAIL hold_load_kept: got md=%b rd=%0d cnt=%0d want 1 5 0", bus.ex_md, bus.ex_rd, bubble_cnt); end
        hold = 1'b0; step();
        checks++; if (bus.ex_valid !== 1'b0 || bubble_cnt !== 4'd1) begin errors++; $display("FAIL hold_then_bubble: got v=%b cnt=%0d want 0 1", bus.ex_valid, bubble_cnt); end
        id_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        flush = 1'b1; step(); flush = 1'b0;
        id_load(5, 1); step();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rw !== 1'b1 || bubble_cnt !== 4'd1) begin errors++; $display("FAIL mid_pre: got v=%b rw=%b cnt=%0d want 1 1 1", bus.ex_valid, bus.ex_rw, bubble_cnt); end
        id_add(7, 5, 6); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %b want 1", stall); end
        reset = 1'b0; #1;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_rw !== 1'b0 || bus.ex_md !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_imm !== 32'h0)
            begin errors++; $display("FAIL mid_async_clear: got v=%b rw=%b md=%b rd=%0d imm=%h want all 0", bus.ex_valid, bus.ex_rw, bus.ex_md, bus.ex_rd, bus.ex_imm); end
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", bubble_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b want 0", stall); end
        step(); reset = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_no_residual: got %b want 0", stall); end
        step();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd7) begin errors++; $display("FAIL mid_resume: got v=%b rd=%0d want 1 7", bus.ex_valid, bus.ex_rd); end
        id_idle();
    endtask

    task automatic test_saturation();
        int exp;
        do_reset();
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            exp = (i + 1 > 15) ? 15 : i + 1;
            checks++; if (bubble_cnt !== 4'(exp)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bubble_cnt, exp); end
        end
        flush = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_mw !== 1'b0) begin errors++; $display("FAIL sat_bubble: got v=%b mw=%b want 0 0", bus.ex_valid, bus.ex_mw); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_source_not_used();
        test_flush();
        test_hold();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the fetch/decode control unit.
- Captures decoded control fields, immediate, PC and register-file read data every cycle, and presents them to the execute stage.
- Detects load-use hazards, drives `stall` back to the PC/fetch logic, inserts bubbles on stall or branch flush, and counts inserted bubbles.

Parameters:
- XLEN, 32, datapath width (PC, IMM, operand data)
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- hold  in  1  external freeze (data-memory wait); register keeps contents
- flush  in  1  branch/jump taken in EX; discard the instruction in ID
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  decoded opcode
- id_funct3  in  3  decoded funct3
- id_rd, id_rs1, id_rs2  in  5 each  register addresses
- id_rw, id_mw, id_md, id_mb, id_mp  in  1 each  reg write, mem write, mem-to-reg (load), imm select, PC select
- id_fs  in  4  ALU function select
- id_strb  in  4  store byte strobes
- id_imm, id_pc  in  XLEN each  immediate, instruction PC
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
- ex_* outputs  out  same widths  registered copies of every id_* field above (ex_valid, ex_opcode … ex_rs2_data)
- stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (reset=0, asynchronous):
  - All ex_* outputs go to 0. This is a bubble: ex_valid=0, ex_rw=0, ex_mw=0.
  - bubble_cnt=0.
  - stall=0 while in reset.
- Source-use rules:
  - rs1_used = id_valid AND opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
  - rs2_used = id_valid AND (id_mb=0 OR id_mw=1).
- Hazard:
  - hazard = ex_valid AND ex_md AND ex_rw AND ex_rd≠0 AND ((rs1_used AND id_rs1=ex_rd) OR (rs2_used AND id_rs2=ex_rd)).
  - stall = hazard AND NOT flush AND reset.
- Register update on each rising edge, first matching rule wins:
  1. hold=1: all ex_* retain their value, bubble_cnt unchanged. hold overrides flush and stall in that cycle. stall is still driven combinationally, so the upstream stage also freezes.
  2. flush=1: load a bubble (all ex_* = 0) and increment bubble_cnt.
  3. hazard=1: load a bubble and increment bubble_cnt. The ID instruction is re-presented next cycle because stall froze the upstream stage.
  4. Otherwise: ex_* ← id_*, with ex_valid ← id_valid.
- Latency and stall length:
  - One cycle from ID to EX.
  - A load-use stall lasts exactly one cycle, because the following bubble clears the hazard.
- Reset deasserted mid-stall: the register is already cleared, so no residual stall appears.
- bubble_cnt saturates at 2^CNT_W−1 and does not wrap.
- Bubbles never write memory or registers (ex_rw=ex_mw=0).

Decomposition:
- Shared package holds:
  - opcode constants OP_LUI, OP_AUIPC, OP_JAL, OP_LOAD;
  - the bubble/NOP encoding (all-zero fields);
  - width constants for register addresses (5), FS (4) and STRB (4).
- One natural sub-module, hazard_detect: the purely combinational rs1_used/rs2_used/hazard/stall logic.
- The top module keeps the register bank and the counter.

Test Plan:
1. Reset mid-stream: reset=0 while ex_valid=1 and ex_rw=1 → all ex_* become 0 immediately, not at the next edge; bubble_cnt=0.
2. Load-use: EX holds load (md=1, rw=1, rd=5); ID holds ADD with rs1=5, mb=0 → stall=1 for one cycle; ex_valid=0 next edge; the ADD appears in EX on the following edge; bubble_cnt=1.
3. Source not used:
   - EX load with rd=5; ID LUI (0110111) with rs1 field=5 → stall=0 and the LUI passes through.
   - EX load with rd=0 and ID rs1=0 → stall=0.
4. Flush with hazard: flush=1 while the load-use condition holds → stall=0; EX gets a bubble; bubble_cnt increments by exactly 1.
5. Hold: hold=1 for 3 cycles with changing id_* → ex_* are frozen; bubble_cnt unchanged; after release the next id_* is captured.
6. Saturation: CNT_W=4, force 20 consecutive flushes → bubble_cnt stops at 15.
